// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter.
// Sends one command byte to the device with the standard inhibit, request-to-send
// and device-clocked sequence, then samples the device ACK bit. It uses the same
// synchronized clock-edge pulses and data sample as the PS/2 byte receiver. The two
// drive-low outputs map onto the open-drain pad output enables.
module ps2_command_out #(
    parameter int unsigned INHIBIT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_command,
    input  logic [7:0] command_byte,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_sent_strb,
    output logic       command_error_strb
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK
    } state_t;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [2:0]       r_bit_idx;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_clk_dl;
    logic             r_dat_dl;
    logic             r_busy;
    logic             r_sent;
    logic             r_err;

    state_t           w_state_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_parity_nxt;
    logic [2:0]       w_idx_nxt;
    logic [INH_W-1:0] w_inh_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_sent_nxt;
    logic             w_err_nxt;
    logic             w_tmo_active;
    logic             w_clk_dl_nxt;
    logic             w_dat_dl_nxt;
    logic             w_busy_nxt;

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_clk_dl  <= 1'b0;
            r_dat_dl  <= 1'b0;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_bit_idx <= w_idx_nxt;
            r_inh_cnt <= w_inh_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_clk_dl  <= w_clk_dl_nxt;
            r_dat_dl  <= w_dat_dl_nxt;
            r_busy    <= w_busy_nxt;
            r_sent    <= w_sent_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state logic: edges advance the frame, the timeout overrides any edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_idx_nxt    = r_bit_idx;
        w_inh_nxt    = r_inh_cnt;
        w_tmo_nxt    = r_tmo_cnt;
        w_sent_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_tmo_active = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP) ||
                       (r_state == S_ACK);

        if (w_tmo_active) begin
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (send_command) begin
                    w_shift_nxt  = command_byte;
                    w_parity_nxt = ~^command_byte;
                    w_inh_nxt    = '0;
                    w_state_nxt  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_START;
                end else begin
                    w_inh_nxt = r_inh_cnt + INH_W'(1);
                end
            end
            S_START: begin
                if (ps2_clk_negedge) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (ps2_clk_negedge) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_idx_nxt   = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (ps2_clk_negedge) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (ps2_clk_negedge) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!ps2_clk_negedge && ps2_clk_posedge) begin
                    w_sent_nxt  = ~ps2_data;
                    w_err_nxt   = ps2_data;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_tmo_active && (r_tmo_cnt == TMO_LAST)) begin
            w_state_nxt = S_IDLE;
            w_sent_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
        end
    end

    // Output decode from the next state, so the registered outputs line up with r_state.
    always_comb begin
        w_clk_dl_nxt = 1'b0;
        w_dat_dl_nxt = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_INHIBIT: w_clk_dl_nxt = 1'b1;
            S_START:   w_dat_dl_nxt = 1'b1;
            S_DATA:    w_dat_dl_nxt = ~w_shift_nxt[0];
            S_PARITY:  w_dat_dl_nxt = ~w_parity_nxt;
            default:   w_dat_dl_nxt = 1'b0;
        endcase
    end

    assign ps2_clk_drive_low  = r_clk_dl;
    assign ps2_data_drive_low = r_dat_dl;
    assign busy               = r_busy;
    assign command_sent_strb  = r_sent;
    assign command_error_strb = r_err;

endmodule

// File: tb/tb_ps2_command_out.sv
// Self-checking bench for ps2_command_out: a device model clocks frames out of the DUT
// while a timeline model predicts every registered output on every cycle.
module tb_ps2_command_out;

    localparam int INH = 10;
    localparam int TMO = 50;

    logic       clk;
    logic       rst;
    logic       send_command;
    logic [7:0] command_byte;
    logic       ps2_clk_posedge;
    logic       ps2_clk_negedge;
    logic       ps2_data;
    logic       ps2_clk_drive_low;
    logic       ps2_data_drive_low;
    logic       busy;
    logic       command_sent_strb;
    logic       command_error_strb;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int n_ok  = 0;
    int n_err = 0;

    // timeline model state
    bit          m_valid = 0;
    bit          m_busy;
    int          m_inh;
    int          m_falls;
    int          m_el;
    logic [10:0] m_wire;
    logic        e_cl, e_dl, e_busy, e_ok, e_err;

    ps2_command_out #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .send_command      (send_command),
        .command_byte      (command_byte),
        .ps2_clk_posedge   (ps2_clk_posedge),
        .ps2_clk_negedge   (ps2_clk_negedge),
        .ps2_data          (ps2_data),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .busy              (busy),
        .command_sent_strb (command_sent_strb),
        .command_error_strb(command_error_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    // Wire position n holds the bit on the data line after n falling edges:
    // 0 start, 1..8 data LSB first, 9 odd parity, 10 stop; 11 falls means awaiting ACK.
    task automatic model_step();
        e_ok  = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
            m_inh   = 0;
            m_falls = 0;
            m_el    = 0;
        end else if (!m_valid) begin
            return;
        end else if (!m_busy) begin
            if (send_command) begin
                m_busy     = 1;
                m_inh      = INH;
                m_wire[0]  = 1'b0;
                m_wire[8:1] = command_byte;
                m_wire[9]  = ($countones(command_byte) % 2 == 0);
                m_wire[10] = 1'b1;
            end
        end else if (m_inh > 0) begin
            m_inh--;
            if (m_inh == 0) begin
                m_falls = 0;
                m_el    = 0;
            end
        end else begin
            if (m_el == TMO - 1) begin
                m_busy = 0;
                e_err  = 1'b1;
            end else begin
                m_el++;
                if (ps2_clk_negedge) begin
                    if (m_falls < 11) m_falls++;
                end else if (ps2_clk_posedge && m_falls == 11) begin
                    m_busy = 0;
                    e_ok   = !ps2_data;
                    e_err  = ps2_data;
                end
            end
        end
        e_busy = m_busy;
        e_cl   = m_busy && (m_inh > 0);
        e_dl   = (m_busy && m_inh == 0 && m_falls <= 10) ? !m_wire[m_falls] : 1'b0;
    endtask

    // Compare process: outputs checked against the model every cycle once reset was seen.
    initial begin : cmp_proc
        logic [4:0] act, expv;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                act  = {ps2_clk_drive_low, ps2_data_drive_low, busy, command_sent_strb, command_error_strb};
                expv = {e_cl, e_dl, e_busy, e_ok, e_err};
                total++;
                if (act !== expv) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d {clk_dl,dat_dl,busy,sent,err} got %b want %b",
                             cyc_n, act, expv);
                end
                if (command_sent_strb)  n_ok++;
                if (command_error_strb) n_err++;
            end
            model_step();
        end
    end

    task automatic start_cmd(input logic [7:0] b);
        command_byte = b;
        send_command = 1'b1;
        tick();
        send_command = 1'b0;
        command_byte = 8'($urandom);
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            ps2_clk_negedge = 1'($urandom_range(0, 1));
            ps2_clk_posedge = !ps2_clk_negedge && ($urandom_range(0, 1) == 1);
            tick();
        end
        ps2_clk_negedge = 1'b0;
        ps2_clk_posedge = 1'b0;
    endtask

    // Ideal device: noise during inhibit, then n_falls clock periods. Rise k (k<=10)
    // samples the line into seen[k]; rise 11 drives ack_lvl. act_kind 1 issues a spurious
    // send of 0x00 after fall act_fall, act_kind 2 pulses rst there and abandons the frame.
    task automatic xfer(input int n_falls, input bit ack_lvl, input int act_fall, input int act_kind,
                        output logic [10:0] seen, output int inh_len, output int t_start);
        int guard;
        seen    = '1;
        inh_len = 0;
        t_start = -1;
        guard   = 0;
        while (guard < 200) begin
            ps2_clk_negedge = 1'b0;
            ps2_clk_posedge = 1'b0;
            if (ps2_clk_drive_low) begin
                inh_len++;
            end else if (ps2_data_drive_low) begin
                break;
            end
            ps2_clk_negedge = 1'($urandom_range(0, 1));
            ps2_clk_posedge = !ps2_clk_negedge && ($urandom_range(0, 1) == 1);
            tick();
            guard++;
        end
        ps2_clk_negedge = 1'b0;
        ps2_clk_posedge = 1'b0;
        check("start_wait", 32'(guard < 200), 32'd1);
        if (guard >= 200) return;
        t_start = cyc_n;
        seen[0] = ~ps2_data_drive_low;
        for (int k = 1; k <= n_falls; k++) begin
            ps2_clk_negedge = 1'b1;
            tick();
            ps2_clk_negedge = 1'b0;
            if (k == act_fall && act_kind == 1) begin
                send_command = 1'b1;
                command_byte = 8'h00;
                tick();
                send_command = 1'b0;
            end
            if (k == act_fall && act_kind == 2) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            gap();
            if (k <= 10) seen[k] = ~ps2_data_drive_low;
            else         ps2_data = ack_lvl;
            ps2_clk_posedge = 1'b1;
            tick();
            ps2_clk_posedge = 1'b0;
            ps2_data = 1'b1;
            gap();
        end
    endtask

    task automatic wait_idle(input int limit, output int t_end);
        int g;
        g = 0;
        while (busy && g < limit) begin
            tick();
            g++;
        end
        check("idle_wait", 32'(busy), 32'd0);
        t_end = cyc_n;
        tick();
    endtask

    initial begin : main
        logic [10:0] seen;
        logic [7:0]  b;
        int inh_len, ts, te, ok0, err0, mode, nf, af, ak;

        rst = 1'b1;
        send_command = 1'b0;
        command_byte = 8'h00;
        ps2_clk_posedge = 1'b0;
        ps2_clk_negedge = 1'b0;
        ps2_data = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outs", 32'({ps2_clk_drive_low, ps2_data_drive_low, busy,
                                 command_sent_strb, command_error_strb}), 32'd0);

        // edge pulses while idle change nothing
        idle_noise(8);
        check("idle_noise_busy", 32'(busy), 32'd0);

        // 0xF4 acked: wire bits 0,0,1,0,1,1,1,1, parity 0 (five ones), stop 1
        ok0 = n_ok; err0 = n_err;
        start_cmd(8'hF4);
        xfer(11, 1'b0, 0, 0, seen, inh_len, ts);
        wait_idle(100, te);
        check("f4_inhibit_len", 32'(inh_len), 32'd10);
        check("f4_start_bit", 32'(seen[0]), 32'd0);
        check("f4_byte", 32'(seen[8:1]), 32'hF4);
        check("f4_parity", 32'(seen[9]), 32'd0);
        check("f4_stop", 32'(seen[10]), 32'd1);
        check("f4_sent_cnt", 32'(n_ok - ok0), 32'd1);
        check("f4_err_cnt", 32'(n_err - err0), 32'd0);

        // 0xFF nacked: parity 1, error strobe only
        ok0 = n_ok; err0 = n_err;
        start_cmd(8'hFF);
        xfer(11, 1'b1, 0, 0, seen, inh_len, ts);
        wait_idle(100, te);
        check("ff_byte", 32'(seen[8:1]), 32'hFF);
        check("ff_parity", 32'(seen[9]), 32'd1);
        check("ff_sent_cnt", 32'(n_ok - ok0), 32'd0);
        check("ff_err_cnt", 32'(n_err - err0), 32'd1);

        // 0xED, device stops after fall 4: error strobe exactly TMO cycles after START
        ok0 = n_ok; err0 = n_err;
        start_cmd(8'hED);
        xfer(4, 1'b0, 0, 0, seen, inh_len, ts);
        wait_idle(200, te);
        check("tmo_delay", 32'(te - ts), 32'd50);
        check("tmo_err_cnt", 32'(n_err - err0), 32'd1);
        check("tmo_sent_cnt", 32'(n_ok - ok0), 32'd0);
        check("tmo_lines", 32'({ps2_clk_drive_low, ps2_data_drive_low}), 32'd0);

        // 0xED with a spurious send of 0x00 mid-DATA: frame unchanged, one strobe
        ok0 = n_ok; err0 = n_err;
        start_cmd(8'hED);
        xfer(11, 1'b0, 3, 1, seen, inh_len, ts);
        wait_idle(100, te);
        check("ed_byte", 32'(seen[8:1]), 32'hED);
        check("ed_parity", 32'(seen[9]), 32'd1);
        check("ed_strobes", 32'((n_ok - ok0) + (n_err - err0)), 32'd1);
        repeat (20) tick();
        check("ed_no_restart", 32'(busy), 32'd0);

        // reset after fall 3 releases everything next cycle, no strobe
        ok0 = n_ok; err0 = n_err;
        start_cmd(8'hA5);
        xfer(11, 1'b0, 3, 2, seen, inh_len, ts);
        check("rst_outs", 32'({ps2_clk_drive_low, ps2_data_drive_low, busy,
                               command_sent_strb, command_error_strb}), 32'd0);
        repeat (5) tick();
        check("rst_no_strobe", 32'((n_ok - ok0) + (n_err - err0)), 32'd0);

        // a following 0xF4 completes normally
        ok0 = n_ok;
        start_cmd(8'hF4);
        xfer(11, 1'b0, 0, 0, seen, inh_len, ts);
        wait_idle(100, te);
        check("post_rst_byte", 32'(seen[8:1]), 32'hF4);
        check("post_rst_sent", 32'(n_ok - ok0), 32'd1);

        // randomized commands: ACK, NACK, timeouts, spurious sends, idle noise
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            mode = $urandom_range(0, 3);
            nf   = (mode == 3) ? $urandom_range(0, 10) : 11;
            ak   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            af   = $urandom_range(1, 10);
            start_cmd(b);
            xfer(nf, mode == 2, af, ak, seen, inh_len, ts);
            wait_idle(200, te);
            if (mode != 3) begin
                check("rnd_frame", 32'(seen), 32'({1'b1, 1'($countones(b) % 2 == 0), b, 1'b0}));
            end
            idle_noise($urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound so a stuck handshake can never hang the run.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
